dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the core's data-memory interface: services load/store requests driven by the memory stage and returns read data for write-back.
- Single-ported, word-organised data RAM with byte-enable writes.
- Configurable fixed read latency with a busy back-pressure signal.
- Error flag for illegal requests.
- Sits between the memory stage (request side) and the write-back stage (consumer of o_dmem_rdata).

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- LATENCY, 1: cycles from request acceptance to read response; legal 1..4.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_dmem_addr  input  32  byte address.
- i_dmem_mask  input  4  byte enables; bit k = byte k (bits 8k+7:8k).
- i_dmem_ren  input  1  read request.
- i_dmem_wen  input  1  write request.
- i_dmem_wdata  input  32  write data, already lane-aligned.
- o_dmem_rdata  output  32  read data; bytes with mask=0 forced to zero.
- o_dmem_rvld  output  1  one-cycle pulse: o_dmem_rdata valid.
- o_busy  output  1  read in flight; requests are ignored while high.
- o_err  output  1  one-cycle pulse: the current response is for an illegal request.

Behaviour:
- Reset: i_rst sampled high at a rising i_clk edge.
  - o_dmem_rdata=0, o_dmem_rvld=0, o_busy=0, o_err=0.
  - FSM goes to IDLE; latency counter=0.
  - RAM contents are not cleared.
- Acceptance: in cycle N when (i_dmem_ren | i_dmem_wen) & ~o_busy. Requests presented while o_busy=1 are ignored; the requester holds them.
- Word index = i_dmem_addr[log2(DEPTH_WORDS)+1:2]. Address bits [1:0] are ignored; lane alignment is carried by the mask.
- Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- A request is illegal if any of these hold:
  - i_dmem_ren & i_dmem_wen;
  - address >= 4*DEPTH_WORDS;
  - mask not in the legal set.
- Write, legal: bytes with mask=1 are updated at the accepting edge. o_busy stays 0. No rvld.
- Write, illegal: RAM unchanged; o_err=1 in cycle N+1 only.
- Read, legal: RAM word is sampled at the accepting edge. A write accepted in an earlier cycle is visible; there is no same-cycle read/write, since both set is illegal.
- Read response: in cycle N+LATENCY, o_dmem_rvld=1 for exactly one cycle. In that cycle o_dmem_rdata = word with disabled bytes zeroed.
- Read, illegal: response arrives with the same timing, with o_dmem_rdata=0 and o_err=1 coincident with rvld. RAM is unchanged.
- o_dmem_rdata holds its last value between responses.
- FSM states:
  - IDLE: accept a read with LATENCY=1 → stay in IDLE; response next cycle.
  - IDLE: accept a read with LATENCY>1 → WAIT; counter=LATENCY-1.
  - IDLE: accept a write → stay in IDLE.
  - WAIT: o_busy=1; counter decrements each cycle. When counter reaches 1, transition to RESP.
  - RESP: o_busy=0, rvld=1. A new request may be accepted in the same cycle: a read goes to WAIT (or back-to-back response when LATENCY=1); otherwise go to IDLE.
- o_busy: high in cycles N+1 .. N+LATENCY-1. Never high when LATENCY=1.
- Throughput:
  - LATENCY=1: one request per cycle; back-to-back reads give consecutive rvld pulses.
  - LATENCY=L: one read per L cycles.
- Reset mid-read: the in-flight response is cancelled. No rvld or err follows reset.
- i_dmem_wdata bytes with mask=0 are don't-care.

Test Plan:
- Reset, then write addr 0x10, mask 1111, data 0xDEADBEEF; read addr 0x10 next cycle (LATENCY=1) → rvld in following cycle, rdata=0xDEADBEEF, err=0.
- Byte write addr 0x12, mask 0100, data 0x00AA0000 over 0xDEADBEEF; read mask 1111 → 0xDEAABEEF. Read mask 1100 → 0xDEAA0000.
- LATENCY=3: read accepted cycle 5 → busy=1 in cycles 6–7; rvld cycle 8. A write held from cycle 6 is accepted in cycle 8 and updates RAM.
- Illegal cases (DEPTH_WORDS=1024):
  - Write addr 0x1000 → err pulse next cycle; RAM unchanged.
  - Read mask 0110 → rvld with rdata=0, err=1.
  - ren=wen=1 → err; no RAM change.
- LATENCY=1: reads to 0x0, 0x4, 0x8 in consecutive cycles → three consecutive rvld pulses with the matching words, busy never set.
- LATENCY=4: assert i_rst two cycles after read acceptance → all outputs 0 next cycle; no rvld afterward. RAM data written before reset still reads back correctly.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the memory stage (master) and
// the data RAM responder (slave).
interface dmem_responder_if;
    logic [31:0] i_dmem_addr;
    logic [3:0]  i_dmem_mask;
    logic        i_dmem_ren;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_wdata;
    logic [31:0] o_dmem_rdata;
    logic        o_dmem_rvld;
    logic        o_busy;
    logic        o_err;

    modport master (
        output i_dmem_addr, i_dmem_mask, i_dmem_ren, i_dmem_wen, i_dmem_wdata,
        input  o_dmem_rdata, o_dmem_rvld, o_busy, o_err
    );

    modport slave (
        input  i_dmem_addr, i_dmem_mask, i_dmem_ren, i_dmem_wen, i_dmem_wdata,
        output o_dmem_rdata, o_dmem_rvld, o_busy, o_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with byte-enable writes, fixed read latency, busy
// back-pressure while a read is in flight, and an error flag for illegal requests.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dmem_responder_if.slave  dmem
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_rvld;
    logic        r_busy;
    logic        r_err;
    logic [31:0] r_hold_data;
    logic        r_hold_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_mask_ok;
    logic          w_addr_ok;
    logic          w_illegal;
    logic [AW-1:0] w_index;
    logic [31:0]   w_bytemask;
    logic [31:0]   w_rd_word;
    logic          w_unused_addr_lsb;

    assign w_accept   = (dmem.i_dmem_ren | dmem.i_dmem_wen) & ~r_busy & ~i_rst;
    assign w_addr_ok  = (dmem.i_dmem_addr[31:AW+2] == '0);
    assign w_index    = dmem.i_dmem_addr[AW+1:2];
    assign w_bytemask = {{8{dmem.i_dmem_mask[3]}}, {8{dmem.i_dmem_mask[2]}},
                         {8{dmem.i_dmem_mask[1]}}, {8{dmem.i_dmem_mask[0]}}};
    assign w_illegal  = (dmem.i_dmem_ren & dmem.i_dmem_wen) | ~w_addr_ok | ~w_mask_ok;
    assign w_rd_word  = w_illegal ? 32'd0 : (r_mem[w_index] & w_bytemask);
    // Lane alignment travels on the mask, so the byte offset is not needed.
    assign w_unused_addr_lsb = ^dmem.i_dmem_addr[1:0];

    always_comb begin
        w_mask_ok = 1'b0;
        case (dmem.i_dmem_mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_mask_ok = 1'b1;
            default:                   w_mask_ok = 1'b0;
        endcase
    end

    // RAM has no reset; contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (w_accept & dmem.i_dmem_wen & ~w_illegal) begin
            for (int k = 0; k < 4; k++) begin
                if (dmem.i_dmem_mask[k]) begin
                    r_mem[w_index][8*k +: 8] <= dmem.i_dmem_wdata[8*k +: 8];
                end
            end
        end
    end

    // ren & wen together is answered on the read path: rvld with zero data and err.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_rdata     <= 32'd0;
            r_rvld      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_hold_data <= 32'd0;
            r_hold_err  <= 1'b0;
        end else begin
            r_rvld <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        if (dmem.i_dmem_ren) begin
                            if (LATENCY == 1) begin
                                r_rvld  <= 1'b1;
                                r_rdata <= w_rd_word;
                                r_err   <= w_illegal;
                            end else begin
                                r_state     <= WAIT;
                                r_cnt       <= 3'(LATENCY - 1);
                                r_busy      <= 1'b1;
                                r_hold_data <= w_rd_word;
                                r_hold_err  <= w_illegal;
                            end
                        end else begin
                            r_err <= w_illegal;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= RESP;
                        r_busy  <= 1'b0;
                        r_rvld  <= 1'b1;
                        r_rdata <= r_hold_data;
                        r_err   <= r_hold_err;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem.o_dmem_rdata = r_rdata;
    assign dmem.o_dmem_rvld  = r_rvld;
    assign dmem.o_busy       = r_busy;
    assign dmem.o_err        = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 3, 4) checked against
// per-instance queues of expected responses.
module tb_dmem_responder;
    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  m;
        logic        r;
        logic        w;
        logic [31:0] wd;
        rsp_t        x;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    rsp_t q1[$];
    rsp_t q3[$];
    rsp_t q4[$];
    vec_t plan[$];

    always #5 clk = ~clk;

    dmem_responder_if if_l1 ();
    dmem_responder_if if_l3 ();
    dmem_responder_if if_l4 ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (.i_clk(clk), .i_rst(rst), .dmem(if_l1));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (.i_clk(clk), .i_rst(rst), .dmem(if_l3));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (.i_clk(clk), .i_rst(rst), .dmem(if_l4));

    task automatic drive(input int sel, input logic [31:0] a, input logic [3:0] m,
                         input logic r, input logic w, input logic [31:0] d);
        case (sel)
            1: begin
                if_l1.i_dmem_addr = a; if_l1.i_dmem_mask = m; if_l1.i_dmem_ren = r;
                if_l1.i_dmem_wen = w;  if_l1.i_dmem_wdata = d;
            end
            3: begin
                if_l3.i_dmem_addr = a; if_l3.i_dmem_mask = m; if_l3.i_dmem_ren = r;
                if_l3.i_dmem_wen = w;  if_l3.i_dmem_wdata = d;
            end
            default: begin
                if_l4.i_dmem_addr = a; if_l4.i_dmem_mask = m; if_l4.i_dmem_ren = r;
                if_l4.i_dmem_wen = w;  if_l4.i_dmem_wdata = d;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [31:0] a, input logic [3:0] m, input logic r,
                                input logic w, input logic [31:0] wd, input logic xv,
                                input logic xe, input logic [31:0] xd);
        vec_t t;
        t.a = a; t.m = m; t.r = r; t.w = w; t.wd = wd;
        t.x.v = xv; t.x.e = xe; t.x.d = xd;
        plan.push_back(t);
    endfunction

    task automatic test_reset();
        logic [34:0] obs [3];
        rst = 1'b1;
        for (int s = 1; s <= 4; s++) drive(s, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        obs[0] = {if_l1.o_dmem_rdata, if_l1.o_dmem_rvld, if_l1.o_busy, if_l1.o_err};
        obs[1] = {if_l3.o_dmem_rdata, if_l3.o_dmem_rvld, if_l3.o_busy, if_l3.o_err};
        obs[2] = {if_l4.o_dmem_rdata, if_l4.o_dmem_rvld, if_l4.o_busy, if_l4.o_err};
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs[i] !== 35'd0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got {rdata,rvld,busy,err}=%h, want 0", i, obs[i]);
            end
        end
        step();
    endtask

    task automatic test_rw_bytes();
        rsp_t exp;
        add(32'h10, 4'b1111, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        add(32'h10, 4'b1111, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
        add(32'h12, 4'b0100, 1'b0, 1'b1, 32'h55AA6677, 1'b0, 1'b0, 32'h0);
        add(32'h10, 4'b1111, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEAABEEF);
        add(32'h10, 4'b1100, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hDEAA0000);
        for (int i = 0; i <= plan.size(); i++) begin
            if (i < plan.size()) begin
                drive(1, plan[i].a, plan[i].m, plan[i].r, plan[i].w, plan[i].wd);
                if (plan[i].x.v || plan[i].x.e) q1.push_back(plan[i].x);
            end else drive(1, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            n_vec++;
            if (if_l1.o_busy !== 1'b0) begin
                n_err++; $display("FAIL rw_busy: got %b, want 0", if_l1.o_busy);
            end
            if (if_l1.o_dmem_rvld !== 1'b0 || if_l1.o_err !== 1'b0) begin
                n_vec++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL rw_extra: got rvld=%b err=%b, want no response",
                             if_l1.o_dmem_rvld, if_l1.o_err);
                end else begin
                    exp = q1.pop_front();
                    if (if_l1.o_dmem_rvld !== exp.v || if_l1.o_err !== exp.e ||
                        (exp.v && if_l1.o_dmem_rdata !== exp.d)) begin
                        n_err++;
                        $display("FAIL rw_resp: got rvld=%b err=%b rdata=%h, want %b %b %h",
                                 if_l1.o_dmem_rvld, if_l1.o_err, if_l1.o_dmem_rdata,
                                 exp.v, exp.e, exp.d);
                    end
                end
            end
            step();
        end
        n_vec++;
        if (q1.size() != 0) begin
            n_err++; $display("FAIL rw_missing: got %0d unanswered, want 0", q1.size());
        end
        q1.delete();
        plan.delete();
    endtask

    task automatic test_back_to_back();
        rsp_t exp;
        add(32'h0, 4'b1111, 1'b0, 1'b1, 32'h03020100, 1'b0, 1'b0, 32'h0);
        add(32'h4, 4'b1111, 1'b0, 1'b1, 32'h07060504, 1'b0, 1'b0, 32'h0);
        add(32'h8, 4'b1111, 1'b0, 1'b1, 32'h0B0A0908, 1'b0, 1'b0, 32'h0);
        add(32'h0, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h03020100);
        add(32'h4, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h07060504);
        add(32'h8, 4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0B0A0908);
        add(32'h8, 4'b0011, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000908);
        add(32'h4, 4'b1000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h07000000);
        add(32'h8, 4'b0010, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00000900);
        for (int i = 0; i <= plan.size(); i++) begin
            if (i < plan.size()) begin
                drive(1, plan[i].a, plan[i].m, plan[i].r, plan[i].w, plan[i].wd);
                if (plan[i].x.v || plan[i].x.e) q1.push_back(plan[i].x);
            end else drive(1, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            n_vec++;
            if (if_l1.o_busy !== 1'b0) begin
                n_err++; $display("FAIL b2b_busy: got %b, want 0", if_l1.o_busy);
            end
            if (if_l1.o_dmem_rvld !== 1'b0 || if_l1.o_err !== 1'b0) begin
                n_vec++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: got rvld=%b err=%b, want no response",
                             if_l1.o_dmem_rvld, if_l1.o_err);
                end else begin
                    exp = q1.pop_front();
                    if (if_l1.o_dmem_rvld !== exp.v || if_l1.o_err !== exp.e ||
                        (exp.v && if_l1.o_dmem_rdata !== exp.d)) begin
                        n_err++;
                        $display("FAIL b2b_resp: got rvld=%b err=%b rdata=%h, want %b %b %h",
                                 if_l1.o_dmem_rvld, if_l1.o_err, if_l1.o_dmem_rdata,
                                 exp.v, exp.e, exp.d);
                    end
                end
            end
            step();
        end
        n_vec++;
        if (q1.size() != 0) begin
            n_err++; $display("FAIL b2b_missing: got %0d unanswered, want 0", q1.size());
        end
        q1.delete();
        plan.delete();
    endtask

    task automatic test_illegal();
        rsp_t exp;
        add(32'h1000,     4'b1111, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 32'h0);
        add(32'h0,        4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h03020100);
        add(32'h10,       4'b0110, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        add(32'h0,        4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h03020100);
        add(32'h10,       4'b1111, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0);
        add(32'h10,       4'b1010, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0);
        add(32'h1000,     4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        add(32'hFFFFFFF0, 4'b1111, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
        add(32'h10,       4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAABEEF);
        add(32'h0,        4'b1111, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h03020100);
        for (int i = 0; i <= plan.size(); i++) begin
            if (i < plan.size()) begin
                drive(1, plan[i].a, plan[i].m, plan[i].r, plan[i].w, plan[i].wd);
                if (plan[i].x.v || plan[i].x.e) q1.push_back(plan[i].x);
            end else drive(1, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            n_vec++;
            if (if_l1.o_busy !== 1'b0) begin
                n_err++; $display("FAIL ill_busy: got %b, want 0", if_l1.o_busy);
            end
            if (if_l1.o_dmem_rvld !== 1'b0 || if_l1.o_err !== 1'b0) begin
                n_vec++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL ill_extra: got rvld=%b err=%b, want no response",
                             if_l1.o_dmem_rvld, if_l1.o_err);
                end else begin
                    exp = q1.pop_front();
                    if (if_l1.o_dmem_rvld !== exp.v || if_l1.o_err !== exp.e ||
                        (exp.v && if_l1.o_dmem_rdata !== exp.d)) begin
                        n_err++;
                        $display("FAIL ill_resp: got rvld=%b err=%b rdata=%h, want %b %b %h",
                                 if_l1.o_dmem_rvld, if_l1.o_err, if_l1.o_dmem_rdata,
                                 exp.v, exp.e, exp.d);
                    end
                end
            end
            step();
        end
        n_vec++;
        if (q1.size() != 0) begin
            n_err++; $display("FAIL ill_missing: got %0d unanswered, want 0", q1.size());
        end
        q1.delete();
        plan.delete();
    endtask

    // Read at k0 holds off the write driven from k1; the write lands at k3, read back at k7.
    task automatic test_latency3();
        rsp_t exp;
        logic exp_busy, exp_rvld;
        drive(3, 32'h20, 4'b1111, 1'b0, 1'b1, 32'h11223344);
        step();
        drive(3, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                drive(3, 32'h20, 4'b1111, 1'b1, 1'b0, 32'd0);
                q3.push_back('{1'b1, 1'b0, 32'h11223344});
            end else if (k <= 3) begin
                drive(3, 32'h24, 4'b1111, 1'b0, 1'b1, 32'hCAFEF00D);
            end else if (k == 4) begin
                drive(3, 32'h24, 4'b1111, 1'b1, 1'b0, 32'd0);
                q3.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
            end else drive(3, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            exp_busy = (k == 1 || k == 2 || k == 5 || k == 6);
            exp_rvld = (k == 3 || k == 7);
            n_vec++;
            if (if_l3.o_busy !== exp_busy || if_l3.o_dmem_rvld !== exp_rvld) begin
                n_err++;
                $display("FAIL lat3_timing k=%0d: got busy=%b rvld=%b, want busy=%b rvld=%b",
                         k, if_l3.o_busy, if_l3.o_dmem_rvld, exp_busy, exp_rvld);
            end
            if (if_l3.o_dmem_rvld === 1'b1 && q3.size() != 0) begin
                exp = q3.pop_front();
                n_vec++;
                if (if_l3.o_dmem_rdata !== exp.d || if_l3.o_err !== exp.e) begin
                    n_err++;
                    $display("FAIL lat3_data k=%0d: got rdata=%h err=%b, want %h %b",
                             k, if_l3.o_dmem_rdata, if_l3.o_err, exp.d, exp.e);
                end
            end
            step();
        end
        n_vec++;
        if (q3.size() != 0) begin
            n_err++; $display("FAIL lat3_missing: got %0d unanswered, want 0", q3.size());
        end
        q3.delete();
    endtask

    task automatic test_reset_mid_read();
        rsp_t exp;
        logic exp_busy, exp_rvld;
        drive(4, 32'h40, 4'b1111, 1'b0, 1'b1, 32'h5A5AA5A5);
        step();
        drive(4, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        step();
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 1) begin
                for (int k = 0; k < 10; k++) begin
                    if (k == 0) drive(4, 32'h40, 4'b1111, 1'b1, 1'b0, 32'd0);
                    else drive(4, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
                    rst = (k == 2);
                    @(negedge clk);
                    if (k == 1) begin
                        n_vec++;
                        if (if_l4.o_busy !== 1'b1) begin
                            n_err++; $display("FAIL rst_busy: got %b, want 1", if_l4.o_busy);
                        end
                    end
                    if (k == 3) begin
                        n_vec++;
                        if (if_l4.o_dmem_rdata !== 32'd0 || if_l4.o_busy !== 1'b0) begin
                            n_err++;
                            $display("FAIL rst_clear: got rdata=%h busy=%b, want 0 0",
                                     if_l4.o_dmem_rdata, if_l4.o_busy);
                        end
                    end
                    if (k >= 3) begin
                        n_vec++;
                        if (if_l4.o_dmem_rvld !== 1'b0 || if_l4.o_err !== 1'b0) begin
                            n_err++;
                            $display("FAIL rst_cancel k=%0d: got rvld=%b err=%b, want 0 0",
                                     k, if_l4.o_dmem_rvld, if_l4.o_err);
                        end
                    end
                    step();
                end
            end else begin
                for (int k = 0; k < 6; k++) begin
                    if (k == 0) begin
                        drive(4, 32'h40, 4'b1111, 1'b1, 1'b0, 32'd0);
                        q4.push_back('{1'b1, 1'b0, 32'h5A5AA5A5});
                    end else drive(4, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
                    @(negedge clk);
                    exp_busy = (k >= 1 && k <= 3);
                    exp_rvld = (k == 4);
                    n_vec++;
                    if (if_l4.o_busy !== exp_busy || if_l4.o_dmem_rvld !== exp_rvld) begin
                        n_err++;
                        $display("FAIL lat4_timing p%0d k=%0d: got busy=%b rvld=%b, want %b %b",
                                 pass, k, if_l4.o_busy, if_l4.o_dmem_rvld, exp_busy, exp_rvld);
                    end
                    if (if_l4.o_dmem_rvld === 1'b1 && q4.size() != 0) begin
                        exp = q4.pop_front();
                        n_vec++;
                        if (if_l4.o_dmem_rdata !== exp.d || if_l4.o_err !== exp.e) begin
                            n_err++;
                            $display("FAIL lat4_data p%0d: got rdata=%h err=%b, want %h %b",
                                     pass, if_l4.o_dmem_rdata, if_l4.o_err, exp.d, exp.e);
                        end
                    end
                    step();
                end
                n_vec++;
                if (q4.size() != 0) begin
                    n_err++; $display("FAIL lat4_missing: got %0d unanswered, want 0", q4.size());
                end
                q4.delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_rw_bytes();
        test_back_to_back();
        test_illegal();
        test_latency3();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
